imm_gen_pipe: RTL

//  Registered, handshaked immediate generator for the decode stage. Accepts an

---
 rtl/imm_gen_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Registered, handshaked RV immediate generator with a 2-entry output/skid buffer
// and a saturating counter of accepted illegal format selects.
module imm_gen_pipe #(
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [2:0]               ImmSrc,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     out_illegal,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : gBadWidth
    $error("imm_gen_pipe: DATA_WIDTH must be 32 or 64");
  end

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_U = 3'b011;
  localparam logic [2:0] SRC_J = 3'b100;

  // Every format fits in 32 signed bits, so decode there and widen once.
  function automatic logic [DATA_WIDTH-1:0] decodeImm(input logic [31:0] ins,
                                                      input logic [2:0]  src);
    logic [31:0] imm32;
    imm32 = '0;
    case (src)
      SRC_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
      SRC_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      SRC_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      SRC_U:   imm32 = {ins[31:12], 12'b0};
      SRC_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    return DATA_WIDTH'($signed(imm32));
  endfunction

  logic                     oValid_q, oValid_d;
  logic [DATA_WIDTH-1:0]    oImm_q, oImm_d;
  logic [TAG_WIDTH-1:0]     oTag_q, oTag_d;
  logic                     oIll_q, oIll_d;
  logic                     kValid_q, kValid_d;
  logic [DATA_WIDTH-1:0]    kImm_q, kImm_d;
  logic [TAG_WIDTH-1:0]     kTag_q, kTag_d;
  logic                     kIll_q, kIll_d;
  logic [ERR_CNT_WIDTH-1:0] errCnt_q, errCnt_d;

  logic                  acc, drn, inIll;
  logic [DATA_WIDTH-1:0] inImm;

  assign inIll = (ImmSrc > SRC_J);
  assign inImm = decodeImm(instr, ImmSrc);
  assign acc   = in_valid && !kValid_q;
  assign drn   = oValid_q && out_ready;

  // The skid entry is only ever occupied while the output entry is full.
  always_comb begin
    oValid_d = oValid_q;
    oImm_d   = oImm_q;
    oTag_d   = oTag_q;
    oIll_d   = oIll_q;
    kValid_d = kValid_q;
    kImm_d   = kImm_q;
    kTag_d   = kTag_q;
    kIll_d   = kIll_q;
    errCnt_d = errCnt_q;

    if (!oValid_q) begin
      if (acc) begin
        oValid_d = 1'b1;
        oImm_d   = inImm;
        oTag_d   = in_tag;
        oIll_d   = inIll;
      end
    end else if (drn) begin
      if (kValid_q) begin
        oImm_d   = kImm_q;
        oTag_d   = kTag_q;
        oIll_d   = kIll_q;
        kValid_d = 1'b0;
      end else if (acc) begin
        oImm_d   = inImm;
        oTag_d   = in_tag;
        oIll_d   = inIll;
      end else begin
        oValid_d = 1'b0;
      end
    end else if (acc) begin
      kValid_d = 1'b1;
      kImm_d   = inImm;
      kTag_d   = in_tag;
      kIll_d   = inIll;
    end

    if (acc && inIll && (errCnt_q != {ERR_CNT_WIDTH{1'b1}}))
      errCnt_d = errCnt_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid_q <= 1'b0;
      oImm_q   <= '0;
      oTag_q   <= '0;
      oIll_q   <= 1'b0;
      kValid_q <= 1'b0;
      kImm_q   <= '0;
      kTag_q   <= '0;
      kIll_q   <= 1'b0;
      errCnt_q <= '0;
    end else begin
      oValid_q <= oValid_d;
      oImm_q   <= oImm_d;
      oTag_q   <= oTag_d;
      oIll_q   <= oIll_d;
      kValid_q <= kValid_d;
      kImm_q   <= kImm_d;
      kTag_q   <= kTag_d;
      kIll_q   <= kIll_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign in_ready    = !kValid_q;
  assign out_valid   = oValid_q;
  assign ImmOp       = oImm_q;
  assign out_tag     = oTag_q;
  assign out_illegal = oIll_q;
  assign err_cnt     = errCnt_q;

endmodule
